// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: receiver state encoding, default protocol timing
// and the ns-to-clock-cycle rounding helper used by both receiver and transmitter.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    LOW       = 2'd1,
    HIGH      = 2'd2
  } rx_state_t;

  localparam int DEF_CLK_MHZ     = 27;
  localparam int DEF_T_MIN_NS    = 150;
  localparam int DEF_T_THRESH_NS = 625;
  localparam int DEF_T_MAX_NS    = 1100;
  localparam int DEF_T_RESET_US  = 50;
  localparam int PIXEL_BITS      = 24;

  // Rounds up so that a threshold is never shorter than the requested time.
  function automatic int ns_to_cycles(input int clk_mhz, input int ns);
    return (clk_mhz * ns + 999) / 1000;
  endfunction

endpackage

// File: rtl/ws2812b_rx_sync.sv
// Two-flop synchronizer for the raw WS2812B line, followed by a delayed level
// register and registered one-cycle rise/fall pulses aligned with that level.
module ws2812b_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta  <= data_in;
      sync  <= meta;
      level <= sync;
      rise  <= sync & ~level;
      fall  <= ~sync & level;
    end
  end

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B stream decoder: pulse-width bit classification, 24-bit pixel assembly
// and reset-gap framing. Optional chain forwarding on dout via WS2812B_RX_FWD_EN.
module ws2812b_rx
  import ws2812b_pkg::*;
#(
  parameter int CLK_MHZ     = DEF_CLK_MHZ,
  parameter int T_MIN_NS    = DEF_T_MIN_NS,
  parameter int T_THRESH_NS = DEF_T_THRESH_NS,
  parameter int T_MAX_NS    = DEF_T_MAX_NS,
  parameter int T_RESET_US  = DEF_T_RESET_US
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_in,
  output logic        pixel_valid,
  output logic [23:0] pixel_data,
  output logic [7:0]  pixel_index,
  output logic        frame_done,
  output logic [8:0]  frame_pixels,
  output logic        err,
  output logic        dout
);

  localparam int T_MIN    = ns_to_cycles(CLK_MHZ, T_MIN_NS);
  localparam int T_THRESH = ns_to_cycles(CLK_MHZ, T_THRESH_NS);
  localparam int T_MAX    = ns_to_cycles(CLK_MHZ, T_MAX_NS);
  localparam int T_RESET  = ns_to_cycles(CLK_MHZ, T_RESET_US * 1000);
  localparam int CW       = $clog2(T_RESET + 1);

  localparam logic [CW-1:0] T_MIN_C    = CW'(T_MIN);
  localparam logic [CW-1:0] T_THRESH_C = CW'(T_THRESH);
  localparam logic [CW-1:0] T_MAX_C    = CW'(T_MAX);
  localparam logic [CW-1:0] T_RESET_C  = CW'(T_RESET);
  localparam logic [4:0]    LAST_BIT   = 5'(PIXEL_BITS - 1);

  logic level, rise, fall;

  ws2812b_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  rx_state_t     state, state_n;
  logic [CW-1:0] low_cnt, low_cnt_n, high_cnt, high_cnt_n;
  logic [CW-1:0] low_inc, high_inc;
  logic [4:0]    bit_cnt, bit_cnt_n;
  logic [22:0]   shift_reg, shift_reg_n;
  logic [8:0]    pixel_cnt, pixel_cnt_n;
  logic          pixel_valid_n, frame_done_n, err_n;
  logic [23:0]   pixel_data_n;
  logic [7:0]    pixel_index_n;
  logic [8:0]    frame_pixels_n;
  logic          bit_val;

  assign low_inc  = (low_cnt == '1) ? low_cnt : low_cnt + CW'(1);
  assign high_inc = (high_cnt == '1) ? high_cnt : high_cnt + CW'(1);
  assign bit_val  = (high_cnt >= T_THRESH_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SYNC_WAIT;
      low_cnt      <= '0;
      high_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      pixel_cnt    <= '0;
      pixel_valid  <= 1'b0;
      pixel_data   <= '0;
      pixel_index  <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      err          <= 1'b0;
    end else begin
      state        <= state_n;
      low_cnt      <= low_cnt_n;
      high_cnt     <= high_cnt_n;
      bit_cnt      <= bit_cnt_n;
      shift_reg    <= shift_reg_n;
      pixel_cnt    <= pixel_cnt_n;
      pixel_valid  <= pixel_valid_n;
      pixel_data   <= pixel_data_n;
      pixel_index  <= pixel_index_n;
      frame_done   <= frame_done_n;
      frame_pixels <= frame_pixels_n;
      err          <= err_n;
    end
  end

  // high_cnt holds the pulse width so far, so a fall in a given cycle means w == high_cnt.
  always_comb begin
    state_n        = state;
    low_cnt_n      = low_cnt;
    high_cnt_n     = high_cnt;
    bit_cnt_n      = bit_cnt;
    shift_reg_n    = shift_reg;
    pixel_cnt_n    = pixel_cnt;
    pixel_valid_n  = 1'b0;
    pixel_data_n   = pixel_data;
    pixel_index_n  = pixel_index;
    frame_done_n   = 1'b0;
    frame_pixels_n = frame_pixels;
    err_n          = 1'b0;

    case (state)
      SYNC_WAIT: begin
        if (level) begin
          low_cnt_n = '0;
        end else if (low_inc >= T_RESET_C) begin
          state_n     = LOW;
          low_cnt_n   = '0;
          bit_cnt_n   = '0;
          pixel_cnt_n = '0;
        end else begin
          low_cnt_n = low_inc;
        end
      end

      LOW: begin
        if (rise) begin
          state_n    = HIGH;
          high_cnt_n = CW'(1);
        end else if (low_inc >= T_RESET_C) begin
          low_cnt_n   = '0;
          bit_cnt_n   = '0;
          pixel_cnt_n = '0;
          if (pixel_cnt != 9'd0 || bit_cnt != 5'd0) begin
            frame_done_n   = 1'b1;
            frame_pixels_n = pixel_cnt;
          end
          if (bit_cnt != 5'd0) begin
            err_n = 1'b1;
          end
        end else begin
          low_cnt_n = low_inc;
        end
      end

      HIGH: begin
        if (fall && high_cnt >= T_MIN_C && high_cnt <= T_MAX_C) begin
          state_n   = LOW;
          low_cnt_n = '0;
          if (bit_cnt == LAST_BIT) begin
            pixel_valid_n = 1'b1;
            pixel_data_n  = {shift_reg, bit_val};
            pixel_index_n = pixel_cnt[8] ? 8'hFF : pixel_cnt[7:0];
            pixel_cnt_n   = pixel_cnt[8] ? pixel_cnt : pixel_cnt + 9'd1;
            bit_cnt_n     = '0;
          end else begin
            shift_reg_n = {shift_reg[21:0], bit_val};
            bit_cnt_n   = bit_cnt + 5'd1;
          end
        end else if (fall || high_cnt >= T_MAX_C) begin
          err_n     = 1'b1;
          state_n   = SYNC_WAIT;
          low_cnt_n = '0;
          bit_cnt_n = '0;
        end else begin
          high_cnt_n = high_inc;
        end
      end

      default: begin
        state_n   = SYNC_WAIT;
        low_cnt_n = '0;
        bit_cnt_n = '0;
      end
    endcase
  end

`ifdef WS2812B_RX_FWD_EN
  logic fwd_open;
  logic frame_end;

  assign frame_end = (state == LOW) && !rise && (low_inc >= T_RESET_C);

  // The gate opens once this block has consumed its own pixel and closes on every frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_open <= 1'b0;
      dout     <= 1'b0;
    end else begin
      dout <= level & fwd_open;
      if (err_n || frame_end || state == SYNC_WAIT) begin
        fwd_open <= 1'b0;
      end else if (pixel_valid_n) begin
        fwd_open <= 1'b1;
      end
    end
  end
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed self-checking bench for ws2812b_rx: framing, bit decoding, glitch,
// overlong pulse, partial pixel, forwarding gate and mid-frame reset.
module tb_ws2812b_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_in;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [8:0]  frame_pixels;
  logic        err;
  logic        dout;

  ws2812b_rx dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .pixel_valid  (pixel_valid),
    .pixel_data   (pixel_data),
    .pixel_index  (pixel_index),
    .frame_done   (frame_done),
    .frame_pixels (frame_pixels),
    .err          (err),
    .dout         (dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          pv_count = 0;
  int          fd_count = 0;
  int          err_count = 0;
  logic [23:0] pv_data_q[$];
  logic [7:0]  pv_idx_q[$];
  logic [8:0]  last_fp = '0;
  logic        last_fd_err = 1'b0;

  // Event recorder, sampled 2 ns after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (pixel_valid === 1'b1) begin
      pv_count++;
      pv_data_q.push_back(pixel_data);
      pv_idx_q.push_back(pixel_index);
    end
    if (frame_done === 1'b1) begin
      fd_count++;
      last_fp = frame_pixels;
      last_fd_err = err;
    end
    if (err === 1'b1) err_count++;
  end

  logic [3:0] din_hist = '0;
  int         fwd_mode = 0;
  int         base_pv, base_fd, base_err;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives a level for a number of cycles; optionally checks dout against the 3-cycle delayed line.
  task automatic applyStimulus(input logic level, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      data_in = level;
      din_hist = {din_hist[2:0], level};
      @(negedge clk);
      if (fwd_mode == 1) checkOutput("dout_gated", {31'd0, dout}, 32'd0);
      else if (fwd_mode == 2) checkOutput("dout_forward", {31'd0, dout}, {31'd0, din_hist[3]});
    end
  endtask

  task automatic send_bit(input logic b);
    if (b) begin
      applyStimulus(1'b1, 22);
      applyStimulus(1'b0, 11);
    end else begin
      applyStimulus(1'b1, 11);
      applyStimulus(1'b0, 22);
    end
  endtask

  task automatic send_pixel(input logic [23:0] p);
    for (int i = 23; i >= 0; i--) send_bit(p[i]);
  endtask

  task automatic mark();
    base_pv  = pv_count;
    base_fd  = fd_count;
    base_err = err_count;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_pixel_valid"}, {31'd0, pixel_valid}, 32'd0);
    checkOutput({tag, "_pixel_data"}, {8'd0, pixel_data}, 32'd0);
    checkOutput({tag, "_pixel_index"}, {24'd0, pixel_index}, 32'd0);
    checkOutput({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    checkOutput({tag, "_frame_pixels"}, {23'd0, frame_pixels}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
    checkOutput({tag, "_dout"}, {31'd0, dout}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    data_in = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    $display("[TB] single pixel frame");
    applyStimulus(1'b0, 1400);
    mark();
    send_pixel(24'hA5C3F0);
    applyStimulus(1'b0, 1400);
    checkOutput("t1_pv_count", pv_count - base_pv, 1);
    checkOutput("t1_data", {8'd0, pv_data_q[base_pv]}, 32'hA5C3F0);
    checkOutput("t1_index", {24'd0, pv_idx_q[base_pv]}, 0);
    checkOutput("t1_fd_count", fd_count - base_fd, 1);
    checkOutput("t1_frame_pixels", {23'd0, last_fp}, 1);
    checkOutput("t1_err_count", err_count - base_err, 0);

    $display("[TB] three pixel frame");
    mark();
    send_pixel(24'h000000);
    send_pixel(24'hFFFFFF);
    send_pixel(24'h123456);
    applyStimulus(1'b0, 1400);
    checkOutput("t2_pv_count", pv_count - base_pv, 3);
    checkOutput("t2_data0", {8'd0, pv_data_q[base_pv]}, 32'h000000);
    checkOutput("t2_index0", {24'd0, pv_idx_q[base_pv]}, 0);
    checkOutput("t2_data1", {8'd0, pv_data_q[base_pv+1]}, 32'hFFFFFF);
    checkOutput("t2_index1", {24'd0, pv_idx_q[base_pv+1]}, 1);
    checkOutput("t2_data2", {8'd0, pv_data_q[base_pv+2]}, 32'h123456);
    checkOutput("t2_index2", {24'd0, pv_idx_q[base_pv+2]}, 2);
    checkOutput("t2_frame_pixels", {23'd0, last_fp}, 3);
    checkOutput("t2_err_count", err_count - base_err, 0);

    $display("[TB] glitch mid-pixel");
    mark();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    applyStimulus(1'b1, 3);
    data_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 checkOutput("t3_err_early", {31'd0, err}, 0);
    @(posedge clk);
    #1 checkOutput("t3_err_latency", {31'd0, err}, 1);
    @(negedge clk);
    applyStimulus(1'b0, 100);
    send_pixel(24'hFFFFFF);
    applyStimulus(1'b0, 1400);
    checkOutput("t3_pv_suppressed", pv_count - base_pv, 0);
    checkOutput("t3_err_count", err_count - base_err, 1);
    checkOutput("t3_fd_suppressed", fd_count - base_fd, 0);
    mark();
    send_pixel(24'h3C3C3C);
    applyStimulus(1'b0, 1400);
    checkOutput("t3_resume_pv", pv_count - base_pv, 1);
    checkOutput("t3_resume_data", {8'd0, pv_data_q[base_pv]}, 32'h3C3C3C);
    checkOutput("t3_resume_fp", {23'd0, last_fp}, 1);

    $display("[TB] overlong high pulse");
    mark();
    applyStimulus(1'b1, 30);
    checkOutput("t4_no_err_yet", err_count - base_err, 0);
    applyStimulus(1'b1, 6);
    checkOutput("t4_err_while_high", err_count - base_err, 1);
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 1400);
    send_pixel(24'h5A5A5A);
    applyStimulus(1'b0, 1400);
    checkOutput("t4_next_pv", pv_count - base_pv, 1);
    checkOutput("t4_next_data", {8'd0, pv_data_q[base_pv]}, 32'h5A5A5A);
    checkOutput("t4_err_total", err_count - base_err, 1);
    checkOutput("t4_fd_count", fd_count - base_fd, 1);

    $display("[TB] partial pixel at frame end");
    mark();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    applyStimulus(1'b0, 1400);
    checkOutput("t5_pv_count", pv_count - base_pv, 0);
    checkOutput("t5_err_count", err_count - base_err, 1);
    checkOutput("t5_fd_count", fd_count - base_fd, 1);
    checkOutput("t5_fd_with_err", {31'd0, last_fd_err}, 1);
    checkOutput("t5_frame_pixels", {23'd0, last_fp}, 0);
    applyStimulus(1'b0, 1400);

    $display("[TB] forwarding gate and mid-pixel reset");
    mark();
    fwd_mode = 1;
    send_pixel(24'h111111);
`ifdef WS2812B_RX_FWD_EN
    fwd_mode = 2;
`endif
    send_pixel(24'h222222);
    applyStimulus(1'b0, 50);
    fwd_mode = 0;
    checkOutput("t6_pv_count", pv_count - base_pv, 2);
    checkOutput("t6_data0", {8'd0, pv_data_q[base_pv]}, 32'h111111);
    checkOutput("t6_data1", {8'd0, pv_data_q[base_pv+1]}, 32'h222222);
    checkOutput("t6_index1", {24'd0, pv_idx_q[base_pv+1]}, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    applyStimulus(1'b1, 5);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("midreset");
    reset = 1'b0;
    data_in = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812b_rx.md
# ws2812b_rx

Single-wire WS2812B stream decoder: samples an asynchronous WS2812B data line, classifies each high pulse as a 0 or 1 bit by width, assembles 24-bit pixel words MSB-first, and reports frame boundaries on the reset (long-low) gap. It sits at a board input, or in loopback against the transmitter, as the receive end of the LED chain protocol, feeding pixel-capture or self-test logic.

## Interface
- CLK_MHZ, 27: clk frequency in MHz; all thresholds are derived from it.
- T_MIN_NS, 150: shortest legal high pulse; anything shorter is a glitch error.
- T_THRESH_NS, 625: high width at or above this decodes as 1, below it as 0.
- T_MAX_NS, 1100: longest legal high pulse; anything longer is an error.
- T_RESET_US, 50: low time that ends a frame.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- data_in  in  1  raw asynchronous WS2812B line.
- pixel_valid  out  1  one-cycle strobe when pixel_data/pixel_index are new.
- pixel_data  out  24  last decoded pixel, first-received bit in [23].
- pixel_index  out  8  index of pixel_data within the current frame, 0-based.
- frame_done  out  1  one-cycle strobe at frame end.
- frame_pixels  out  9  pixel count of the frame just ended, valid with frame_done.
- err  out  1  one-cycle strobe on a protocol violation.
- dout  out  1  forwarded stream (see Configuration).

## Operation
- Cycle constants: c = (CLK_MHZ*ns + 999)/1000, rounded up. At 27 MHz: T_MIN=5, T_THRESH=17, T_MAX=30, T_RESET=1350.
- data_in passes through a 2-FF synchronizer, then a registered edge detector.
- States: SYNC_WAIT, LOW, HIGH.
  - SYNC_WAIT: entered on reset and after any error. Counts consecutive low cycles; any high clears the count. At T_RESET, go to LOW with bit_cnt=0 and pixel_index=0. No frame_done is issued on this exit.
  - LOW: rising edge clears the high counter and enters HIGH. If the low count reaches T_RESET, frame ends: frame_done if at least one pixel was received or bit_cnt≠0; stay in LOW and clear counters.
  - HIGH: on a falling edge, classify width w (cycles high). w<T_MIN or w>T_MAX gives err. Otherwise shift in (w≥T_THRESH). Return to LOW with the low counter cleared. If the high counter exceeds T_MAX while still high, raise err immediately without waiting for the edge.
- On the 24th bit: pixel_valid, pixel_data updated, pixel_index = count before increment, bit_cnt back to 0.
- Frame end with bit_cnt≠0 (partial pixel): err and frame_done in the same cycle; frame_pixels counts whole pixels only; the partial pixel is discarded.
- On any err: discard the partial pixel, go to SYNC_WAIT, no frame_done.
- Pixel counter saturates at 256 (frame_pixels 9 bits). pixel_index saturates at 255; pixels beyond 256 still strobe pixel_valid with index 255.
- Counters are $clog2(T_RESET+1) bits wide and saturate; they never wrap.

## Timing
- Reset values: pixel_valid=0, pixel_data=0, pixel_index=0, frame_done=0, frame_pixels=0, err=0, dout=0; state=SYNC_WAIT.
- Latency: if data_in is first sampled low at edge N, the synchronized level changes at N+2 and the decision is registered so that pixel_valid/err is high in cycle N+3.
- High width is measured in synchronized cycles, with ±1 cycle tolerance from synchronization.
- frame_done asserts in the cycle after the low count reaches T_RESET.
- All strobes last exactly one cycle. There is no backpressure: a consumer must accept pixel_valid on every assertion. Minimum pixel spacing is 24 × (T_MIN+1) cycles.
- A reset mid-frame drops everything and requires a fresh T_RESET low before decoding resumes.

## Configuration
- WS2812B_RX_FWD_EN defined: dout reproduces the synchronized data_in (3-cycle delay) but is held low for the first 24 bits of each frame. Bit 25 onward is forwarded, so the block behaves as one LED in a chain. Gating re-arms at each frame end and in SYNC_WAIT.
- Not defined: dout is constant 0 and the forwarding logic is absent.

## Structure
- ws2812b_pkg: state enum, the ns_to_cycles rounding function, and default timing constants shared with the transmitter.
- Sub-module ws2812b_rx_sync: 2-FF synchronizer plus registered rise/fall pulse outputs. The top level contains the FSM, counters, shift register and forwarding gate.

## Test plan
- Wait ≥1350 low cycles, then send one pixel 0xA5C3F0 (high 22/low 11 cycles for 1, high 11/low 22 for 0), then 1350 low cycles. Required: pixel_valid once with data 0xA5C3F0 and index 0; frame_done with frame_pixels=1; no err.
- Send 3 pixels 0x000000, 0xFFFFFF, 0x123456. Required: indices 0, 1, 2 with matching data; frame_pixels=3.
- Insert a 3-cycle high glitch mid-pixel. Required: err 3 cycles after its fall, no pixel_valid, and decoding resumes only after 1350 low cycles.
- Hold a high pulse for 40 cycles. Required: err while the line is still high; the next frame decodes normally.
- Send 10 bits, then a reset gap. Required: err and frame_done together, frame_pixels=0.
- With WS2812B_RX_FWD_EN, send pixels 0x111111 and 0x222222. Required: dout stays low for the first pixel and reproduces the waveform of 0x222222 delayed by 3 cycles. Assert reset mid-pixel: all outputs return to 0.
